// File: rtl/seq_mul_32bit.sv
// Unsigned 32x32 -> 64-bit shift-and-add multiplier with start/done handshake.
// One shared 32-bit carry-lookahead adder adds the multiplicand into the high partial-product word.

module cla_32bit (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_ci,
    output logic [31:0] o_sum,
    output logic        o_co
);
    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [32:0] w_c;

    assign w_g    = i_a & i_b;
    assign w_p    = i_a ^ i_b;
    assign w_c[0] = i_ci;

    // Full lookahead inside each 4-bit group; group carries chain between groups.
    for (genvar grp = 0; grp < 8; grp++) begin : g_group
        localparam int B = grp * 4;
        logic w_groupG;
        logic w_groupP;

        assign w_c[B+1] = w_g[B] | (w_p[B] & w_c[B]);
        assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B])
                        | (w_p[B+1] & w_p[B] & w_c[B]);
        assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1])
                        | (w_p[B+2] & w_p[B+1] & w_g[B])
                        | (w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);

        assign w_groupG = w_g[B+3] | (w_p[B+3] & w_g[B+2])
                        | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                        | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
        assign w_groupP = &w_p[B+3:B];

        assign w_c[B+4] = w_groupG | (w_groupP & w_c[B]);
    end

    assign o_sum = w_p ^ w_c[31:0];
    assign o_co  = w_c[32];
endmodule

module seq_mul_32bit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_p;
    logic [2*WIDTH-1:0] r_product;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH-1:0]   w_sum;
    logic               w_co;
    logic [2*WIDTH-1:0] w_pNext;

    cla_32bit u_cla (
        .i_a   (r_p[2*WIDTH-1:WIDTH]),
        .i_b   (r_mcand),
        .i_ci  (1'b0),
        .o_sum (w_sum),
        .o_co  (w_co)
    );

    // Add-then-shift: the adder carry becomes the new MSB, so nothing is lost.
    assign w_pNext = r_p[0] ? {w_co, w_sum, r_p[WIDTH-1:1]}
                            : {1'b0, r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_p       <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand <= a;
                        r_p     <= {{WIDTH{1'b0}}, b};
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_p   <= w_pNext;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        r_product <= w_pNext;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;
endmodule

// File: tb/tb_seq_mul_32bit.sv
// Self-checking bench for seq_mul_32bit: transaction-level reference model compared every cycle,
// plus directed literal products, latency, ignored-start and mid-calculation reset scenarios.

module tb_seq_mul_32bit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int passCount = 0;
    int checkCount = 0;
    int cycle = 0;
    bit checkEn = 1'b0;

    // Reference model: remaining calc cycles, pending result, done flag, visible product.
    int          mLeft = 0;
    bit          mDone = 1'b0;
    logic [63:0] mPending = '0;
    logic [63:0] mProduct = '0;

    seq_mul_32bit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // A product takes 32 calc cycles, then one done cycle; start only counts when idle.
    always @(posedge clk) begin
        if (rst) begin
            mLeft    = 0;
            mDone    = 1'b0;
            mProduct = '0;
        end else if (mDone) begin
            mDone = 1'b0;
        end else if (mLeft > 0) begin
            mLeft--;
            if (mLeft == 0) begin
                mDone    = 1'b1;
                mProduct = mPending;
            end
        end else if (start) begin
            mLeft    = 32;
            mPending = 64'(a) * 64'(b);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
        end else begin
            passCount++;
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model_busy", 64'(busy), 64'(mLeft > 0));
            checkOutput("model_done", 64'(done), 64'(mDone));
            checkOutput("model_product", product, mProduct);
        end
    end

    task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB);
        @(posedge clk);
        #2;
        a     = opA;
        b     = opB;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic waitDone(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("done_seen", 64'(seen), 64'd1);
    endtask

    task automatic countDones(input int window, output int dones, output logic [63:0] lastProd);
        dones    = 0;
        lastProd = product;
        for (int i = 0; i < window; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                lastProd = product;
            end
        end
    endtask

    initial begin
        bit          seen;
        int          dones;
        int          busyCycles;
        int          doneCycles[3];
        logic [63:0] lastProd;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset held for two edges, then idle with no start.
        rst = 1'b1;
        @(negedge clk);
        checkEn = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        countDones(5, dones, lastProd);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done_count", 64'(dones), 64'd0);
        checkOutput("reset_product", product, 64'd0);

        // Zero multiplicand: 32 busy cycles, then a zero product.
        applyStimulus(32'd0, 32'h1234_5678);
        busyCycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busyCycles++;
        end
        checkOutput("zero_done_seen", 64'(seen), 64'd1);
        checkOutput("zero_busy_cycles", 64'(busyCycles), 64'd32);
        checkOutput("zero_product", product, 64'h0);
        @(negedge clk);
        checkOutput("zero_done_pulse_width", 64'(done), 64'd0);

        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone(seen);
        checkOutput("max_product", product, 64'hFFFF_FFFE_0000_0001);

        applyStimulus(32'd15520, 32'd35000);
        waitDone(seen);
        checkOutput("mid_product", product, 64'd543200000);

        // Start pulse during calculation must be ignored.
        applyStimulus(32'd60000, 32'd60000);
        repeat (9) @(negedge clk);
        a     = 32'd1;
        b     = 32'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        countDones(40, dones, lastProd);
        checkOutput("ignore_start_done_count", 64'(dones), 64'd1);
        checkOutput("ignore_start_product", lastProd, 64'd3600000000);
        checkOutput("ignore_start_held", product, 64'd3600000000);

        // Reset in mid-calculation abandons the product with no done pulse.
        applyStimulus(32'd100, 32'd200);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset_busy", 64'(busy), 64'd0);
        checkOutput("midreset_product", product, 64'd0);
        countDones(40, dones, lastProd);
        checkOutput("midreset_done_count", 64'(dones), 64'd0);
        applyStimulus(32'd25, 32'd30);
        waitDone(seen);
        checkOutput("restart_product", product, 64'd750);

        // Continuous start: one result every 34 cycles.
        @(posedge clk);
        #2;
        a     = 32'd2;
        b     = 32'd5;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            waitDone(seen);
            doneCycles[k] = cycle;
            checkOutput("stream_product", product, 64'd10);
        end
        start = 1'b0;
        checkOutput("stream_interval_1", 64'(doneCycles[1] - doneCycles[0]), 64'd34);
        checkOutput("stream_interval_2", 64'(doneCycles[2] - doneCycles[1]), 64'd34);
        @(negedge clk);

        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = $urandom;
            applyStimulus(ra, rb);
            waitDone(seen);
            checkOutput("random_product", product, 64'(ra) * 64'(rb));
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
